// File: rtl/analyzer_text_scan.sv
`timescale 1ns/1ps
// Text-mode raster front end: a COLS x ROWS character buffer written through a cursor-driven
// stream, raster timing, and a 3-stage pipeline through the external glyph ROM to the video outputs.
module analyzer_text_scan #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC_S = 656,
    parameter int H_SYNC_E = 752,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC_S = 490,
    parameter int V_SYNC_E = 492,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic [7:0] char_data,
    input  logic       cur_set,
    input  logic [6:0] cur_x,
    input  logic [4:0] cur_y,
    input  logic       clr_start,
    output logic       clr_busy,
    output logic [7:0] font_ascii,
    output logic [3:0] font_row,
    output logic [2:0] font_col,
    input  logic       font_pixel,
    output logic       vid_hsync,
    output logic       vid_vsync,
    output logic       vid_de,
    output logic       vid_pixel
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [6:0]    cur_x_q, cur_x_d;
    logic [4:0]    cur_y_q, cur_y_d;
    logic [4:0]    y_next;
    logic [AW-1:0] char_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          de0, hs0, vs0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    mem_q [CELLS];
    logic [7:0]    rd_data_q;

    logic          de1_q, hs1_q, vs1_q;
    logic [3:0]    row1_q;
    logic [2:0]    col1_q;
    logic          de2_q, hs2_q, vs2_q;
    logic [7:0]    font_ascii_q, font_ascii_d;
    logic [3:0]    font_row_q;
    logic [2:0]    font_col_q;
    logic          vid_hsync_q, vid_vsync_q, vid_de_q, vid_pixel_q;

    // char_valid/char_ready: a character transfers on a rising edge where both are high;
    // char_ready never depends on char_valid, and the producer holds char_data while char_valid waits.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        wr_en      = 1'b0;
        wr_addr    = clr_addr_q;
        wr_data    = 8'h20;
        char_ready = 1'b0;
        clr_busy   = 1'b0;
        y_next     = (int'(cur_y_q) == ROWS - 1) ? 5'd0 : cur_y_q + 5'd1;
        char_addr  = AW'(int'(cur_y_q) * COLS + int'(cur_x_q));
        case (state_q)
            ST_CLEAR: begin
                clr_busy = 1'b1;
                wr_en    = 1'b1;
                if (int'(clr_addr_q) == CELLS - 1) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                    cur_x_d    = 7'd0;
                    cur_y_d    = 5'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: begin
                char_ready = ~clr_start & ~cur_set;
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (cur_set) begin
                    if (int'(cur_x) < COLS && int'(cur_y) < ROWS) begin
                        cur_x_d = cur_x;
                        cur_y_d = cur_y;
                    end
                end else if (char_valid) begin
                    if (char_data == 8'h0A) begin
                        cur_x_d = 7'd0;
                        cur_y_d = y_next;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = char_addr;
                        wr_data = char_data;
                        if (int'(cur_x_q) == COLS - 1) begin
                            cur_x_d = 7'd0;
                            cur_y_d = y_next;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (int'(h_q) == H_TOTAL - 1) begin
            h_d = '0;
            v_d = (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + 1'b1;
        end
        de0          = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
        hs0          = ~((int'(h_q) >= H_SYNC_S) && (int'(h_q) < H_SYNC_E));
        vs0          = ~((int'(v_q) >= V_SYNC_S) && (int'(v_q) < V_SYNC_E));
        rd_addr      = AW'((int'(v_q) >> 4) * COLS + (int'(h_q) >> 3));
        // The glyph code is only refreshed for visible cells; blanking keeps the last one.
        font_ascii_d = de1_q ? rd_data_q : font_ascii_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            cur_x_q      <= 7'd0;
            cur_y_q      <= 5'd0;
            h_q          <= '0;
            v_q          <= '0;
            de1_q        <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            row1_q       <= 4'd0;
            col1_q       <= 3'd0;
            de2_q        <= 1'b0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            font_ascii_q <= 8'd0;
            font_row_q   <= 4'd0;
            font_col_q   <= 3'd0;
            vid_hsync_q  <= 1'b1;
            vid_vsync_q  <= 1'b1;
            vid_de_q     <= 1'b0;
            vid_pixel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            h_q          <= h_d;
            v_q          <= v_d;
            de1_q        <= de0;
            hs1_q        <= hs0;
            vs1_q        <= vs0;
            row1_q       <= v_q[3:0];
            col1_q       <= h_q[2:0];
            de2_q        <= de1_q;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;
            font_ascii_q <= font_ascii_d;
            font_row_q   <= row1_q;
            font_col_q   <= col1_q;
            vid_hsync_q  <= hs2_q;
            vid_vsync_q  <= vs2_q;
            vid_de_q     <= de2_q;
            vid_pixel_q  <= font_pixel & de2_q;
        end
    end

    // Buffer has no reset; the post-reset clear sweep initialises it. Read-first on collisions.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (de0)   rd_data_q <= mem_q[rd_addr];
    end

    assign font_ascii = font_ascii_q;
    assign font_row   = font_row_q;
    assign font_col   = font_col_q;
    assign vid_hsync  = vid_hsync_q;
    assign vid_vsync  = vid_vsync_q;
    assign vid_de     = vid_de_q;
    assign vid_pixel  = vid_pixel_q;
endmodule
